fpu_req_arbiter: RTL and testbench



---
 rtl/fpu_req_arbiter_pkg.sv | 41 ++++
 rtl/fpu_req_arbiter_if.sv | 54 +++++
 rtl/fpu_req_arbiter_rr.sv | 31 +++
 rtl/fpu_req_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_fpu_req_arbiter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_req_arbiter_pkg.sv
// Shared types and constants for the FPU request arbiter.
// Holds the FPU opcode enum, the controller state enum, the latched
// request record and the exception flag layout.
package fpu_arb_pkg;

   typedef enum logic [2:0] {
      ADD  = 3'd0,
      SUB  = 3'd1,
      MUL  = 3'd2,
      DIV  = 3'd3,
      SQRT = 3'd4
   } fpu_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_e;

   typedef struct packed {
      fpu_op_e     op;
      logic [1:0]  rmode;
      logic [31:0] opa;
      logic [31:0] opb;
   } fpu_req_t;

   // Canonical quiet NaN returned when the watchdog ends an operation.
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   // Exception flag bit positions: {invalid, divzero, overflow, underflow, inexact}.
   localparam int unsigned EXC_INVALID   = 4;
   localparam int unsigned EXC_DIVZERO   = 3;
   localparam int unsigned EXC_OVERFLOW  = 2;
   localparam int unsigned EXC_UNDERFLOW = 1;
   localparam int unsigned EXC_INEXACT   = 0;

   // Flags reported with a watchdog response: invalid only.
   localparam logic [4:0] EXC_TIMEOUT = 5'(1 << EXC_INVALID);

endpackage

// File: rtl/fpu_req_arbiter_if.sv
// Bus interface between the requesters, the arbiter and the FPU core.
// slave  : the arbiter side (accepts requests, drives responses and the FPU).
// master : the requester/FPU side (drives requests, FPU completion).
interface fpu_req_arbiter_if #(
   parameter int unsigned NUM_REQ = 4
);
   localparam int unsigned IDW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ*3-1:0]  req_op;
   logic [NUM_REQ*2-1:0]  req_rmode;
   logic [NUM_REQ*32-1:0] req_opa;
   logic [NUM_REQ*32-1:0] req_opb;

   logic [NUM_REQ-1:0]    resp_valid;
   logic [NUM_REQ-1:0]    resp_ready;
   logic [31:0]           resp_result;
   logic [4:0]            resp_exc;
   logic                  resp_timeout;

   logic                  fpu_start;
   logic [2:0]            fpu_op;
   logic [1:0]            fpu_rmode;
   logic [31:0]           fpu_opa;
   logic [31:0]           fpu_opb;
   logic                  fpu_done;
   logic [31:0]           fpu_result;
   logic [4:0]            fpu_exc;

   logic                  busy;
   logic [IDW-1:0]        grant_id;

   modport slave (
      input  req_valid, req_op, req_rmode, req_opa, req_opb,
      input  resp_ready,
      input  fpu_done, fpu_result, fpu_exc,
      output req_ready,
      output resp_valid, resp_result, resp_exc, resp_timeout,
      output fpu_start, fpu_op, fpu_rmode, fpu_opa, fpu_opb,
      output busy, grant_id
   );

   modport master (
      output req_valid, req_op, req_rmode, req_opa, req_opb,
      output resp_ready,
      output fpu_done, fpu_result, fpu_exc,
      input  req_ready,
      input  resp_valid, resp_result, resp_exc, resp_timeout,
      input  fpu_start, fpu_op, fpu_rmode, fpu_opa, fpu_opb,
      input  busy, grant_id
   );

endinterface

// File: rtl/fpu_req_arbiter_rr.sv
// Combinational round-robin picker: returns the first set request bit at
// or after the pointer, wrapping modulo NUM_REQ, as a one-hot grant and
// an index.
module fpu_rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   localparam int unsigned IDW    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDW-1:0]     i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDW-1:0]     o_idx,
   output logic               o_valid
);

   // Scan candidates in priority order starting from the pointer.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!o_valid && i_req[j] && (j == (32'(i_ptr) + k) % NUM_REQ)) begin
               o_valid    = 1'b1;
               o_idx      = IDW'(j);
               o_grant[j] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/fpu_req_arbiter.sv
// Shares one non-pipelined, variable-latency FPU among NUM_REQ requesters.
// Round-robin request selection, single op in flight, valid/ready response
// returned to the owning requester.
// Optional watchdog: define FPU_ARB_TIMEOUT_EN to end a WAIT that exceeds
// TIMEOUT_CYCLES with a QNaN/invalid response flagged by resp_timeout.
import fpu_arb_pkg::*;

module fpu_req_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   fpu_req_arbiter_if.slave   bus
);

   localparam int unsigned IDW = $clog2(NUM_REQ);

   arb_state_e         r_state;
   arb_state_e         w_state_nxt;
   logic [IDW-1:0]     r_rr_ptr;
   logic [IDW-1:0]     r_grant_id;
   fpu_req_t           r_req;
   fpu_req_t           w_sel_req;
   logic [31:0]        r_result;
   logic [4:0]         r_exc;

   logic [NUM_REQ-1:0] w_win_onehot;
   logic [IDW-1:0]     w_win_idx;
   logic               w_win_valid;
   logic               w_accept;
   logic               w_resp_hs;
   logic               w_to_fire;
   logic [NUM_REQ-1:0] w_req_ready;
   logic [NUM_REQ-1:0] w_resp_valid;
   logic               w_fpu_start;

   fpu_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .i_req   (bus.req_valid),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_win_onehot),
      .o_idx   (w_win_idx),
      .o_valid (w_win_valid)
   );

   assign w_accept  = (r_state == IDLE) && w_win_valid;
   assign w_resp_hs = (r_state == RESP) && bus.resp_ready[r_grant_id];

   // Mux the winning requester's fields out of the flattened request buses.
   always_comb begin
      w_sel_req = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (w_win_onehot[i]) begin
            w_sel_req.op    = fpu_op_e'(bus.req_op[3*i +: 3]);
            w_sel_req.rmode = bus.req_rmode[2*i +: 2];
            w_sel_req.opa   = bus.req_opa[32*i +: 32];
            w_sel_req.opb   = bus.req_opb[32*i +: 32];
         end
      end
   end

`ifdef FPU_ARB_TIMEOUT_EN
   localparam int unsigned TOW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TOW-1:0] r_wait_cnt;
   logic           r_timeout;

   // Count WAIT cycles; cleared while issuing so WAIT always starts at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_cnt <= '0;
      end else if (r_state == ISSUE) begin
         r_wait_cnt <= '0;
      end else if (r_state == WAIT) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end

   // Fires in the last WAIT cycle so RESP starts TIMEOUT_CYCLES after WAIT entry.
   assign w_to_fire = (r_state == WAIT) && !bus.fpu_done &&
                      (r_wait_cnt == TOW'(TIMEOUT_CYCLES - 1));

   // Remember whether the pending response came from the watchdog.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timeout <= 1'b0;
      end else if (r_state == WAIT) begin
         r_timeout <= w_to_fire;
      end
   end

   assign bus.resp_timeout = r_timeout && (r_state == RESP);
`else
   logic w_unused_timeout_cfg;

   assign w_to_fire            = 1'b0;
   assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign bus.resp_timeout     = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic and state-decoded handshake outputs.
   always_comb begin
      w_state_nxt  = r_state;
      w_req_ready  = '0;
      w_resp_valid = '0;
      w_fpu_start  = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_req_ready = w_win_onehot;
            if (w_win_valid) begin
               w_state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            w_fpu_start = 1'b1;
            w_state_nxt = WAIT;
         end
         WAIT: begin
            if (bus.fpu_done || w_to_fire) begin
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
               w_resp_valid[i] = (r_grant_id == IDW'(i));
            end
            if (w_resp_hs) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Latch the granted request and its owner on acceptance; held through RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req      <= '0;
         r_grant_id <= '0;
      end else if (w_accept) begin
         r_req      <= w_sel_req;
         r_grant_id <= w_win_idx;
      end
   end

   // Advance the round-robin pointer past the owner once its response is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr <= '0;
      end else if (w_resp_hs) begin
         r_rr_ptr <= (r_grant_id == IDW'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
      end
   end

   // Capture the FPU completion (or watchdog result) only while waiting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result <= '0;
         r_exc    <= '0;
      end else if (r_state == WAIT) begin
         if (bus.fpu_done) begin
            r_result <= bus.fpu_result;
            r_exc    <= bus.fpu_exc;
         end else if (w_to_fire) begin
            r_result <= QNAN;
            r_exc    <= EXC_TIMEOUT;
         end
      end
   end

   assign bus.req_ready   = w_req_ready;
   assign bus.resp_valid  = w_resp_valid;
   assign bus.resp_result = r_result;
   assign bus.resp_exc    = r_exc;
   assign bus.fpu_start   = w_fpu_start;
   assign bus.fpu_op      = r_req.op;
   assign bus.fpu_rmode   = r_req.rmode;
   assign bus.fpu_opa     = r_req.opa;
   assign bus.fpu_opb     = r_req.opb;
   assign bus.busy        = (r_state != IDLE);
   assign bus.grant_id    = r_grant_id;

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Directed self-checking bench for fpu_req_arbiter with a small FPU model.
module tb_fpu_req_arbiter;
   import fpu_arb_pkg::*;

   localparam int unsigned NREQ = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fpu_req_arbiter_if #(.NUM_REQ(NREQ)) u_if ();

   fpu_req_arbiter #(
      .NUM_REQ        (NREQ),
      .TIMEOUT_CYCLES (64)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
   );

   int n_checks = 0;
   int n_errors = 0;
   int unsigned cyc_now = 0;
   always @(posedge clk) cyc_now++;

   // FPU model controls (written by the main sequence only).
   int unsigned model_lat  = 3;
   bit          model_hang = 1'b0;
   bit          model_echo = 1'b0;
   logic [31:0] model_res  = '0;
   logic [4:0]  model_exc  = '0;
   int unsigned stray_req  = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_rdy"},  64'(u_if.req_ready), 0);
      check_val({tag, "_rv"},   64'(u_if.resp_valid), 0);
      check_val({tag, "_res"},  64'({u_if.resp_result, u_if.resp_exc, u_if.resp_timeout}), 0);
      check_val({tag, "_fpu"},  64'({u_if.fpu_start, u_if.fpu_op, u_if.fpu_rmode, u_if.fpu_opa}), 0);
      check_val({tag, "_opb"},  64'(u_if.fpu_opb), 0);
      check_val({tag, "_busy"}, 64'({u_if.busy, u_if.grant_id}), 0);
   endtask

   task automatic set_req(input int unsigned lane, input logic [2:0] op, input logic [1:0] rm,
                          input logic [31:0] a, input logic [31:0] b);
      u_if.req_op[lane*3 +: 3]     = op;
      u_if.req_rmode[lane*2 +: 2]  = rm;
      u_if.req_opa[lane*32 +: 32]  = a;
      u_if.req_opb[lane*32 +: 32]  = b;
   endtask

   // Steps negedges until a response lane is valid; returns steps taken.
   task automatic wait_resp(input string tag, output int unsigned n);
      n = 0;
      do begin
         @(negedge clk); #1;
         n++;
      end while (u_if.resp_valid == '0 && n < 200);
      check_val({tag, "_resp_seen"}, 64'(u_if.resp_valid != '0), 1);
   endtask

   // FPU model: done L cycles after fpu_start, or a stray pulse on request.
   initial begin
      int unsigned cnt;
      int unsigned stray_seen;
      cnt = 0;
      stray_seen = 0;
      u_if.fpu_done   = 1'b0;
      u_if.fpu_result = '0;
      u_if.fpu_exc    = '0;
      forever begin
         @(negedge clk);
         u_if.fpu_done = 1'b0;
         if (stray_req != stray_seen) begin
            stray_seen      = stray_req;
            u_if.fpu_done   = 1'b1;
            u_if.fpu_result = 32'hDEAD_BEEF;
            u_if.fpu_exc    = 5'b11111;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               u_if.fpu_done   = 1'b1;
               u_if.fpu_result = model_echo ? u_if.fpu_opb : model_res;
               u_if.fpu_exc    = model_exc;
            end
         end else if (u_if.fpu_start && !model_hang) begin
            cnt = model_lat;
         end
      end
   end

   initial begin
      int unsigned n;
      int unsigned t_acc;
      int unsigned t_last;
      logic [NREQ-1:0] exp_oh;

      rst_n = 1'b0;
      u_if.req_valid  = '0;
      u_if.req_op     = '0;
      u_if.req_rmode  = '0;
      u_if.req_opa    = '0;
      u_if.req_opb    = '0;
      u_if.resp_ready = '0;
      t_last = 0;

      // Reset state.
      repeat (3) @(negedge clk);
      #1 check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Single requester, L=3: start at +1, response at +5.
      model_lat = 3; model_echo = 1'b0; model_res = 32'h4040_0000; model_exc = 5'b00001;
      set_req(0, ADD, 2'b00, 32'h3F80_0000, 32'h4000_0000);
      u_if.req_valid = 4'b0001;
      #1 check_val("t1_ready", 64'(u_if.req_ready), 64'b0001);
      @(negedge clk);
      u_if.req_valid = '0;
      #1;
      check_val("t1_start", 64'(u_if.fpu_start), 1);
      check_val("t1_fpu", 64'({u_if.fpu_op, u_if.fpu_rmode}), 64'({ADD, 2'b00}));
      check_val("t1_opab", {u_if.fpu_opa, u_if.fpu_opb}, 64'h3F80_0000_4000_0000);
      check_val("t1_busy", 64'({u_if.busy, u_if.grant_id}), 64'({1'b1, 2'd0}));
      wait_resp("t1", n);
      check_val("t1_latency", 64'(n + 1), 5);
      check_val("t1_lane", 64'(u_if.resp_valid), 64'b0001);
      check_val("t1_result", 64'(u_if.resp_result), 64'h4040_0000);
      check_val("t1_exc", 64'({u_if.resp_exc, u_if.resp_timeout}), 64'b000010);
      check_val("t1_opa_hold", 64'(u_if.fpu_opa), 64'h3F80_0000);
      u_if.resp_ready = 4'b0001;
      @(negedge clk); #1;
      check_val("t1_idle", 64'({u_if.busy, u_if.resp_valid}), 0);
      u_if.resp_ready = '0;

      // Stray done in IDLE: nothing changes, old result kept.
      stray_req++;
      repeat (5) begin
         @(negedge clk); #1;
         check_val("stray_busy", 64'(u_if.busy), 0);
         check_val("stray_rv", 64'(u_if.resp_valid), 0);
      end
      check_val("stray_result", 64'(u_if.resp_result), 64'h4040_0000);

      // Reset mid-WAIT (rr_ptr now 1 -> requester 1); late done must be ignored.
      model_lat = 5;
      set_req(1, MUL, 2'b01, 32'h4040_0000, 32'h4000_0000);
      u_if.req_valid = 4'b0010;
      #1 check_val("t3_ready", 64'(u_if.req_ready), 64'b0010);
      @(negedge clk);
      u_if.req_valid = '0;
      repeat (2) @(negedge clk);
      #1 check_val("t3_in_wait", 64'({u_if.busy, u_if.resp_valid}), 64'h10);
      rst_n = 1'b0;
      #1 check_all_zero("t3_rst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) begin
         @(negedge clk); #1;
         check_val("t3_no_resp", 64'({u_if.busy, u_if.resp_valid}), 0);
      end
      check_all_zero("t3_after");

      // Fairness: all four requesting, L=3, ready high; expect 0,1,2,3,0,1,2,3 every 6 cycles.
      model_lat = 3; model_echo = 1'b1; model_exc = 5'b00000;
      for (int unsigned i = 0; i < NREQ; i++) begin
         set_req(i, 3'(i), 2'(i), 32'h10 + i, 32'hB000_0000 | i);
      end
      @(negedge clk);
      u_if.resp_ready = '1;
      u_if.req_valid  = '1;
      #1;
      for (int unsigned op = 0; op < 8; op++) begin
         exp_oh = NREQ'(1) << (op % NREQ);
         n = 0;
         while (u_if.req_ready == '0 && n < 20) begin
            @(negedge clk); #1;
            n++;
         end
         check_val("fair_grant", 64'(u_if.req_ready), 64'(exp_oh));
         t_acc = cyc_now;
         if (op > 0) check_val("fair_interval", 64'(t_acc - t_last), 6);
         t_last = t_acc;
         wait_resp("fair", n);
         check_val("fair_lane", 64'(u_if.resp_valid), 64'(exp_oh));
         check_val("fair_gid", 64'(u_if.grant_id), 64'(op % NREQ));
         check_val("fair_result", 64'(u_if.resp_result), 64'(32'hB000_0000 | (op % NREQ)));
         @(negedge clk);
         if (op == 7) u_if.req_valid = '0;
         #1;
      end
      u_if.resp_ready = '0;

      // Backpressure: lanes 2,3 request, lane 2 response stalled 10 cycles.
      model_lat = 2;
      @(negedge clk);
      u_if.resp_ready = 4'b1000;
      u_if.req_valid  = 4'b1100;
      #1 check_val("bp_grant2", 64'(u_if.req_ready), 64'b0100);
      @(negedge clk);
      u_if.req_valid = 4'b1000;
      wait_resp("bp", n);
      repeat (10) begin
         check_val("bp_rv", 64'(u_if.resp_valid), 64'b0100);
         check_val("bp_result", 64'(u_if.resp_result), 64'hB000_0002);
         check_val("bp_no_ready", 64'(u_if.req_ready), 0);
         @(negedge clk); #1;
      end
      u_if.resp_ready = 4'b1100;
      @(negedge clk); #1;
      check_val("bp_grant3", 64'(u_if.req_ready), 64'b1000);
      @(negedge clk);
      u_if.req_valid = '0;
      wait_resp("bp3", n);
      check_val("bp3_lane", 64'(u_if.resp_valid), 64'b1000);
      check_val("bp3_result", 64'(u_if.resp_result), 64'hB000_0003);
      @(negedge clk);
      u_if.resp_ready = '0;

      // FPU never completes (rr_ptr now 0 -> requester 0).
      model_hang = 1'b1; model_echo = 1'b0;
      set_req(0, DIV, 2'b10, 32'h3F80_0000, 32'h0000_0000);
      @(negedge clk);
      u_if.req_valid = 4'b0001;
      #1 check_val("to_ready", 64'(u_if.req_ready), 64'b0001);
      t_acc = cyc_now;
      @(negedge clk);
      u_if.req_valid = '0;
`ifdef FPU_ARB_TIMEOUT_EN
      wait_resp("to", n);
      check_val("to_latency", 64'(cyc_now - t_acc), 66);
      check_val("to_lane", 64'(u_if.resp_valid), 64'b0001);
      check_val("to_result", 64'(u_if.resp_result), 64'h7FC0_0000);
      check_val("to_exc", 64'(u_if.resp_exc), 64'b10000);
      check_val("to_flag", 64'(u_if.resp_timeout), 1);
      stray_req++;
      repeat (3) begin
         @(negedge clk); #1;
         check_val("to_stray_hold", 64'({u_if.resp_valid, u_if.resp_result}), 64'({4'b0001, 32'h7FC0_0000}));
      end
      u_if.resp_ready = 4'b0001;
      @(negedge clk); #1;
      check_val("to_done", 64'({u_if.busy, u_if.resp_timeout}), 0);
      u_if.resp_ready = '0;
`else
      repeat (80) @(negedge clk);
      #1;
      check_val("hang_wait", 64'({u_if.busy, u_if.resp_valid}), 64'h10);
      check_val("hang_flag", 64'(u_if.resp_timeout), 0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1 check_val("hang_recover", 64'(u_if.busy), 0);
`endif
      model_hang = 1'b0;

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
